// File: rtl/jt6295_shreg_rst.sv
`default_nettype none
// ============================================================================
// Module   : jt6295_shreg_rst
// Purpose  : WIDTH-bit, STAGES-deep clock-enabled delay line, async active-low clear
// Revision : 1.0
// ============================================================================

module jt6295_shreg_rst #(
  parameter int   WIDTH  = 1,
  parameter int   STAGES = 1,
  parameter logic RSTVAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop
);

  localparam logic [WIDTH-1:0] C_RST_WORD = {WIDTH{RSTVAL}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] r_q;

    if (k == 0) begin : g_head
      assign w_in = din;
    end else begin : g_body
      assign w_in = g_stage[k-1].r_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_q <= C_RST_WORD;
      end else if (clk_en) begin
        r_q <= w_in;
      end
    end
  end

  // Straight from the last flop, so drop can be fed back into din.
  assign drop = g_stage[STAGES-1].r_q;

endmodule

`default_nettype wire

// File: tb/tb_jt6295_shreg_rst.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt6295_shreg_rst
// Purpose  : self-checking bench for jt6295_shreg_rst against a history model
// Revision : 1.0
// ============================================================================

module tb_jt6295_shreg_rst;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a, en_b, en_c, en_d, en_e;
  logic [11:0] din_a;
  logic        din_b;
  logic [7:0]  din_d;
  logic [2:0]  din_e;
  logic [11:0] x_c;
  logic [11:0] din_c;
  logic [11:0] drop_a, drop_c;
  logic        drop_b;
  logic [7:0]  drop_d;
  logic [2:0]  drop_e;

  int checks, failures;

  // Every value captured on an enabled edge since the last reset, in order.
  logic [11:0] h_a [0:1023];
  logic        h_b [0:1023];
  logic [7:0]  h_d [0:1023];
  logic [2:0]  h_e [0:1023];
  int n_a, n_b, n_c, n_d, n_e;

  always #5 clk = ~clk;

  assign din_c = drop_c + x_c;

  jt6295_shreg_rst #(.WIDTH(12), .STAGES(4)) u_a (
    .clk(clk), .rst(rst), .clk_en(en_a), .din(din_a), .drop(drop_a));
  jt6295_shreg_rst #(.WIDTH(1), .STAGES(4)) u_b (
    .clk(clk), .rst(rst), .clk_en(en_b), .din(din_b), .drop(drop_b));
  jt6295_shreg_rst #(.WIDTH(12), .STAGES(4)) u_c (
    .clk(clk), .rst(rst), .clk_en(en_c), .din(din_c), .drop(drop_c));
  jt6295_shreg_rst #(.WIDTH(8), .STAGES(1)) u_d (
    .clk(clk), .rst(rst), .clk_en(en_d), .din(din_d), .drop(drop_d));
  jt6295_shreg_rst #(.WIDTH(3), .STAGES(2), .RSTVAL(1'b1)) u_e (
    .clk(clk), .rst(rst), .clk_en(en_e), .din(din_e), .drop(drop_e));

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    n_a = 0; n_b = 0; n_c = 0; n_d = 0; n_e = 0;
  endtask

  // drop shows the value captured STAGES enabled edges ago, else the reset word.
  // The accumulator holds STAGES slots each adding x once per STAGES enabled edges.
  task automatic check_all();
    chk("w12s4", drop_a, (n_a >= 4) ? h_a[n_a-4] : 12'h000);
    chk("w1s4", {11'b0, drop_b}, (n_b >= 4) ? {11'b0, h_b[n_b-4]} : 12'h000);
    chk("accum", drop_c, 12'(x_c * (n_c / 4)));
    chk("w8s1", {4'b0, drop_d}, (n_d >= 1) ? {4'b0, h_d[n_d-1]} : 12'h000);
    chk("w3s2rv1", {9'b0, drop_e}, (n_e >= 2) ? {9'b0, h_e[n_e-2]} : 12'h007);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      if (en_a) begin h_a[n_a] = din_a; n_a++; end
      if (en_b) begin h_b[n_b] = din_b; n_b++; end
      if (en_c) n_c++;
      if (en_d) begin h_d[n_d] = din_d; n_d++; end
      if (en_e) begin h_e[n_e] = din_e; n_e++; end
    end
    #1;
    check_all();
  endtask

  task automatic randomize_inputs(input logic with_c);
    en_a  = ($urandom_range(0, 3) != 0);
    en_b  = ($urandom_range(0, 3) != 0);
    en_d  = ($urandom_range(0, 3) != 0);
    en_e  = ($urandom_range(0, 3) != 0);
    if (with_c) en_c = ($urandom_range(0, 3) != 0);
    din_a = 12'($urandom);
    din_b = 1'($urandom);
    din_d = 8'($urandom);
    din_e = 3'($urandom);
  endtask

  initial begin
    logic [5:0] en_pat;
    checks = 0;
    failures = 0;
    reset_model();
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; en_d = 1'b1; en_e = 1'b1;
    din_a = 12'hABC; din_b = 1'b1; din_d = 8'h5A; din_e = 3'b010; x_c = 12'd5;

    // Held in reset with data and enable active: outputs stay at the reset word.
    repeat (5) step();
    rst = 1'b1;

    // Latency: 1..6 on successive edges; the 1-bit line sees a held 1.
    for (int i = 1; i <= 6; i++) begin
      din_a = 12'(i);
      step();
    end
    din_b = 1'b0;
    repeat (4) step();

    // Enable gaps: 12'h123 reaches drop only on the fourth enabled edge.
    din_a = 12'h123;
    en_a  = 1'b1;
    step();
    din_a  = 12'h000;
    en_pat = 6'b101100;
    for (int i = 5; i >= 0; i--) begin
      en_a = en_pat[i];
      step();
    end

    // Random traffic on every instance, accumulator enable included.
    for (int i = 0; i < 200; i++) begin
      randomize_inputs(1'b1);
      step();
    end

    // Asynchronous clear mid-cycle, well away from any clock edge.
    rst = 1'b0;
    #2;
    reset_model();
    check_all();
    x_c = 12'h7FF;
    step();
    step();
    rst = 1'b1;

    // Accumulator with a large step so the slots wrap modulo 4096.
    for (int i = 0; i < 150; i++) begin
      randomize_inputs(1'b1);
      step();
    end

    // Clear with every enable low: reset must not depend on clk_en.
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0; en_e = 1'b0;
    rst = 1'b0;
    #2;
    reset_model();
    check_all();
    x_c = 12'd5;
    step();
    rst = 1'b1;

    // Directed accumulator: 5, 10, 15 after enabled edges 4, 8, 12.
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; en_d = 1'b1; en_e = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      randomize_inputs(1'b0);
      en_a = 1'b1;
      step();
      if (i % 4 == 0) chk("accum_directed", drop_c, 12'(5 * (i / 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/jt6295_shreg_rst.md
Name: jt6295_shreg_rst

Overview:
- Parameterised multi-bit delay line: a WIDTH-bit word passes through STAGES clock-enabled register stages, with asynchronous clear of every stage.
- Used inside the ADPCM datapath to align the channel-enable flag with the pipelined delta computation (1-bit, 4 stages).
- Also holds the 12-bit accumulated sound sample, whose output is fed back combinationally to the input (12-bit, 4 stages).
- Output must therefore be purely registered.

Parameters:
- WIDTH, 1, bit width of din/drop; legal range 1 and up.
- STAGES, 1, number of register stages (latency in enabled cycles); legal range 1 and up.
- RSTVAL, 1'b0, per-bit value loaded into every stage on reset. All bits of every stage take this value; default all-zero.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (low = reset asserted); clears all stages immediately, independent of clk/clk_en.
- clk_en  input  1  clock enable; stages shift only on rising clk edges where clk_en=1.
- din  input  WIDTH  data into stage 0.
- drop  output  WIDTH  contents of the last stage (stage STAGES-1).

Behaviour:
- Storage: STAGES registers of WIDTH bits, s[0]..s[STAGES-1].
- One clock; reset is asynchronous and active-low.
- Reset:
  - While rst=0, every bit of every stage equals RSTVAL, so drop = all RSTVAL (0 by default).
  - Reset takes effect asynchronously, including mid-shift.
  - Release is sampled on the next clk edge; the first shift can occur on the first rising edge with rst=1 and clk_en=1.
- Shift, on rising clk with rst=1 and clk_en=1:
  - s[0] <= din; s[k] <= s[k-1] for k=1..STAGES-1.
  - All updates are simultaneous (non-blocking semantics).
- Hold: on rising clk with clk_en=0, all stages keep their value. Enable gaps of any length stretch latency in clk cycles but not in enabled cycles.
- drop = s[STAGES-1], driven directly from a register.
  - There is no combinational path from din or clk_en to drop, so drop may be fed back through logic to din (accumulator loop) without a loop.
- Latency: a value presented on din at enabled edge n appears on drop right after enabled edge n+STAGES-1.
  - That is, it is visible for the STAGES-th enabled cycle after capture.
  - STAGES=1 degenerates to a single enabled register.
- Bit independence: each bit column is an independent shift chain; no arithmetic, no sign handling.
- Feedback loop use: with drop fed back as din = drop + x, STAGES interleaved accumulators exist, one per pipeline slot. Each slot accumulates its own x every STAGES enabled cycles. Wrap-around is modular 2^WIDTH, handled by external logic, not this block.
- X-safety: after reset all stages are defined; no uninitialised state may reach drop.

Test Plan:
- Reset: WIDTH=12, STAGES=4, din=12'hABC, clk_en=1, rst=0 for 5 cycles -> drop=12'h000 throughout. Assert rst=0 asynchronously mid-cycle after loading data -> drop=0 before next edge.
- Latency: WIDTH=12, STAGES=4, rst=1, clk_en=1, din sequence 1,2,3,4,5,6 on successive edges -> drop reads 0,0,0,1,2,3 after edges 1..6.
- Clock enable: same config, din=12'h123 captured, then clk_en toggles 1,0,0,1,1,0,1 -> value reaches drop only after the 4th enabled edge. Drop unchanged on every clk_en=0 edge.
- 1-bit instance: WIDTH=1, STAGES=4, din=1 held from edge 1 -> drop=1 from after edge 4. Then din=0 -> drop returns to 0 four enabled edges later.
- Feedback accumulator: WIDTH=12, STAGES=4, din = drop + 12'd5 (external), clk_en=1 from reset -> drop after enabled edges 4,8,12 = 5,10,15. Starting with drop near 12'hFFF -> wraps modulo 4096.
- Degenerate: STAGES=1, WIDTH=8 -> drop equals din from previous enabled edge; reset value 8'h00.
